// File: rtl/hex_ascii_pkg.sv
// Shared constants and state encoding for the hex-to-ASCII serializer.
package hex_ascii_pkg;

  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_X  = 8'h78;
  localparam logic [7:0] ASC_UA = 8'h41;
  localparam logic [7:0] ASC_LA = 8'h61;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PFX0  = 3'd1,
    PFX1  = 3'd2,
    DIGIT = 3'd3,
    CR    = 3'd4,
    LF    = 3'd5
  } state_t;

  // Nibble index counter needs at least one bit even for a single-digit word.
  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/hex_ascii_serializer_nibble.sv
// Combinational 4-bit value to ASCII hex digit, case selectable per call.
module nibble_to_ascii
  import hex_ascii_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       lower,
  output logic [7:0] chr
);

  always_comb begin
    chr = ASC_0 + {4'h0, nib};
    if (nib >= 4'd10) begin
      chr = (lower ? ASC_LA : ASC_UA) + {4'h0, nib} - 8'd10;
    end
  end

endmodule

// File: rtl/hex_ascii_serializer.sv
// Prints one DATA_W-bit word as ASCII hex, MSB nibble first, with optional
// "0x" prefix and CR/LF terminator; valid/ready on both sides.
module hex_ascii_serializer
  import hex_ascii_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int PREFIX_EN = 0,
  parameter int TERM_EN   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_lower,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic              busy
);

  localparam int DIGITS = DATA_W / 4;
  localparam int IDX_W  = idx_width(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  if ((DATA_W % 4) != 0 || DATA_W < 4 || DATA_W > 64) begin : g_bad_width
    $error("hex_ascii_serializer: DATA_W must be a multiple of 4 in 4..64");
  end

  state_t             r_state;
  logic [DATA_W-1:0]  r_word;
  logic               r_lower;
  logic [IDX_W-1:0]   r_idx;
  logic               r_ready;
  logic               r_valid;
  logic               r_busy;
  logic [7:0]         r_char;

  logic [DATA_W-1:0]  w_word;
  logic               w_lower;
  logic [IDX_W-1:0]   w_idx;
  logic [3:0]         w_nib;
  logic [7:0]         w_chr;
  logic               w_capture;
  logic               w_out_hs;

  // The converter always looks at the digit that will be shown next: the MSB
  // of the incoming word while idle, otherwise the stored word.
  always_comb begin
    w_word    = (r_state == IDLE) ? in_data  : r_word;
    w_lower   = (r_state == IDLE) ? in_lower : r_lower;
    w_idx     = (r_state == DIGIT) ? (r_idx - 1'b1) : LAST_IDX;
    w_nib     = w_word[{w_idx, 2'b00} +: 4];
    w_capture = in_valid && r_ready;
    w_out_hs  = r_valid && out_ready;
  end

  nibble_to_ascii u_nib (
    .nib   (w_nib),
    .lower (w_lower),
    .chr   (w_chr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_lower <= 1'b0;
      r_idx   <= '0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_char  <= 8'h00;
    end else if (r_state == IDLE) begin
      if (w_capture) begin
        r_word  <= in_data;
        r_lower <= in_lower;
        r_idx   <= LAST_IDX;
        r_ready <= 1'b0;
        r_busy  <= 1'b1;
        r_valid <= 1'b1;
        if (PREFIX_EN != 0) begin
          r_state <= PFX0;
          r_char  <= ASC_0;
        end else begin
          r_state <= DIGIT;
          r_char  <= w_chr;
        end
      end else begin
        r_ready <= 1'b1;
      end
    end else if (w_out_hs) begin
      case (r_state)
        PFX0: begin
          r_state <= PFX1;
          r_char  <= ASC_X;
        end
        PFX1: begin
          r_state <= DIGIT;
          r_idx   <= LAST_IDX;
          r_char  <= w_chr;
        end
        DIGIT: begin
          if (r_idx != '0) begin
            r_idx  <= r_idx - 1'b1;
            r_char <= w_chr;
          end else if (TERM_EN != 0) begin
            r_state <= CR;
            r_char  <= ASC_CR;
          end else begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        CR: begin
          r_state <= LF;
          r_char  <= ASC_LF;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_ready;
  assign out_valid = r_valid;
  assign out_char  = r_char;
  assign busy      = r_busy;

endmodule

// File: tb/tb_hex_ascii_serializer.sv
// Bench for hex_ascii_serializer: four parameterisations checked against a
// character-stream model built from the printing rules.
module tb_hex_ascii_serializer;

  localparam int NI = 4;
  localparam int DW[NI]  = '{16, 16, 8, 12};
  localparam int PFX[NI] = '{0, 0, 1, 1};
  localparam int TRM[NI] = '{1, 0, 1, 0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid [NI];
  logic        in_ready [NI];
  logic [63:0] in_data [NI];
  logic        in_lower [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic [7:0]  out_char [NI];
  logic        busy [NI];

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  hex_ascii_serializer #(.DATA_W(16), .PREFIX_EN(0), .TERM_EN(1)) u_dut0 (
    .clk(clk), .reset(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0][15:0]), .in_lower(in_lower[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_char(out_char[0]), .busy(busy[0]));
  hex_ascii_serializer #(.DATA_W(16), .PREFIX_EN(0), .TERM_EN(0)) u_dut1 (
    .clk(clk), .reset(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1][15:0]), .in_lower(in_lower[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_char(out_char[1]), .busy(busy[1]));
  hex_ascii_serializer #(.DATA_W(8), .PREFIX_EN(1), .TERM_EN(1)) u_dut2 (
    .clk(clk), .reset(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2][7:0]), .in_lower(in_lower[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_char(out_char[2]), .busy(busy[2]));
  hex_ascii_serializer #(.DATA_W(12), .PREFIX_EN(1), .TERM_EN(0)) u_dut3 (
    .clk(clk), .reset(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(in_data[3][11:0]), .in_lower(in_lower[3]), .out_valid(out_valid[3]),
    .out_ready(out_ready[3]), .out_char(out_char[3]), .busy(busy[3]));

  // Expected character stream for one word on instance k.
  function automatic void build_expected(input int k, input logic [63:0] d, input bit lower);
    int n;
    exp_q.delete();
    if (PFX[k] != 0) begin
      exp_q.push_back("0");
      exp_q.push_back("x");
    end
    for (int i = DW[k] / 4 - 1; i >= 0; i--) begin
      n = int'((d >> (4 * i)) & 64'hF);
      if (n < 10) exp_q.push_back(8'(48 + n));
      else if (lower) exp_q.push_back(8'(97 + n - 10));
      else exp_q.push_back(8'(65 + n - 10));
    end
    if (TRM[k] != 0) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  task automatic run_word(input int k, input logic [63:0] d, input bit lower,
                          input int pct, input bit hold_valid);
    int n = 0;
    int guard = 0;
    bit stalled = 0;
    bit rdy;
    logic [7:0] held = 8'h00;
    build_expected(k, d, lower);
    while (!in_ready[k] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (in_ready[k] !== 1'b1) begin
      $display("FAIL ready_wait k=%0d got in_ready=%b want 1", k, in_ready[k]);
      fails++;
    end
    in_valid[k]  = 1'b1;
    in_data[k]   = d;
    in_lower[k]  = lower;
    out_ready[k] = (pct >= 100);
    @(negedge clk);
    if (hold_valid) begin
      in_data[k]  = ~d;
      in_lower[k] = ~lower;
    end else begin
      in_valid[k] = 1'b0;
      in_data[k]  = {$urandom, $urandom};
    end
    tests++;
    if (out_valid[k] !== 1'b1) begin
      $display("FAIL first_latency k=%0d got out_valid=%b want 1", k, out_valid[k]);
      fails++;
    end
    guard = 0;
    while (n < exp_q.size() && guard < 400) begin
      tests++;
      if (out_valid[k] !== 1'b1) begin
        $display("FAIL bubble k=%0d char#%0d got out_valid=%b want 1", k, n, out_valid[k]);
        fails++;
      end else begin
        if (stalled) begin
          tests++;
          if (out_char[k] !== held) begin
            $display("FAIL stall_hold k=%0d got %h want %h", k, out_char[k], held);
            fails++;
          end
        end
        tests++;
        if (busy[k] !== 1'b1 || in_ready[k] !== 1'b0) begin
          $display("FAIL busy_flags k=%0d got busy=%b in_ready=%b want 1/0", k, busy[k], in_ready[k]);
          fails++;
        end
        rdy = (pct >= 100) || ($urandom_range(99) < pct);
        out_ready[k] = rdy;
        if (rdy) begin
          tests++;
          if (out_char[k] !== exp_q[n]) begin
            $display("FAIL char k=%0d idx=%0d got %h want %h", k, n, out_char[k], exp_q[n]);
            fails++;
          end
          n++;
          stalled = 0;
          if (n == exp_q.size() && hold_valid) in_valid[k] = 1'b0;
        end else begin
          stalled = 1;
          held = out_char[k];
        end
      end
      @(negedge clk);
      guard++;
    end
    tests++;
    if (n < exp_q.size()) begin
      $display("FAIL timeout k=%0d got %0d chars want %0d", k, n, exp_q.size());
      fails++;
    end
    tests++;
    if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
      $display("FAIL word_end k=%0d got valid=%b ready=%b busy=%b want 0/1/0",
               k, out_valid[k], in_ready[k], busy[k]);
      fails++;
    end
    in_valid[k] = 1'b0;
    $display("[TB] word k=%0d data=%h lower=%0d ready%%=%0d chars=%0d", k, d, lower, pct, n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      tests++;
      if (in_ready[k] !== 1'b0 || out_valid[k] !== 1'b0 || out_char[k] !== 8'h00 || busy[k] !== 1'b0) begin
        $display("FAIL reset_state k=%0d got ready=%b valid=%b char=%h busy=%b want 0/0/00/0",
                 k, in_ready[k], out_valid[k], out_char[k], busy[k]);
        fails++;
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      tests++;
      if (in_ready[k] !== 1'b1) begin
        $display("FAIL reset_release k=%0d got in_ready=%b want 1", k, in_ready[k]);
        fails++;
      end
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    run_word(0, 64'h1A2F, 1'b0, 100, 1'b0);
  endtask

  task automatic test_lower_hold();
    run_word(1, 64'hBEEF, 1'b1, 100, 1'b1);
  endtask

  task automatic test_backpressure();
    run_word(0, 64'h0F0F, 1'b0, 50, 1'b0);
    run_word(0, 64'h0F0F, 1'b1, 30, 1'b0);
  endtask

  task automatic test_reset_midword();
    in_valid[0] = 1'b1;
    in_data[0] = 64'h1234;
    in_lower[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
      $display("FAIL midword_reset got valid=%b ready=%b busy=%b want 0/0/0",
               out_valid[0], in_ready[0], busy[0]);
      fails++;
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      $display("FAIL midword_release got ready=%b valid=%b want 1/0", in_ready[0], out_valid[0]);
      fails++;
    end
    $display("[TB] mid-word reset checked");
    run_word(0, 64'h5678, 1'b0, 100, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] words[4] = '{64'hAAAA, 64'h5555, 64'hAAAA, 64'h5555};
    logic [7:0] stream[$];
    int wi = 0;
    int pos;
    for (int w = 0; w < 4; w++) begin
      build_expected(0, words[w], 1'b0);
      foreach (exp_q[i]) stream.push_back(exp_q[i]);
    end
    out_ready[0] = 1'b1;
    in_lower[0] = 1'b0;
    in_valid[0] = 1'b1;
    for (int c = 0; c <= 28; c++) begin
      if (wi < 4) in_data[0] = words[wi];
      else in_valid[0] = 1'b0;
      pos = (c == 0) ? 6 : (c - 1) % 7;
      tests++;
      if (in_ready[0] !== (pos == 6) || out_valid[0] !== (pos < 6)) begin
        $display("FAIL b2b_flags cyc=%0d got ready=%b valid=%b want %b/%b",
                 c, in_ready[0], out_valid[0], pos == 6, pos < 6);
        fails++;
      end else if (pos < 6) begin
        tests++;
        if (out_char[0] !== stream[(c - 1) / 7 * 6 + pos]) begin
          $display("FAIL b2b_char cyc=%0d got %h want %h", c, out_char[0], stream[(c - 1) / 7 * 6 + pos]);
          fails++;
        end
      end
      if (in_ready[0] && in_valid[0]) wi++;
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    $display("[TB] back-to-back words captured=%0d", wi);
  endtask

  task automatic test_prefix();
    run_word(2, 64'h00, 1'b0, 100, 1'b0);
    run_word(3, 64'($urandom_range(4095)), 1'($urandom_range(1)), 100, 1'b0);
    run_word(3, 64'hABC, 1'b1, 60, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_word(int'($urandom_range(NI - 1)), {$urandom, $urandom}, 1'($urandom_range(1)),
               int'($urandom_range(30, 100)), 1'($urandom_range(1)));
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b0;
      in_data[k] = '0;
      in_lower[k] = 1'b0;
      out_ready[k] = 1'b0;
    end
    test_reset();
    test_basic();
    test_lower_hold();
    test_backpressure();
    test_reset_midword();
    test_back_to_back();
    test_prefix();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
